mac_array_ctrl: RTL and testbench

Sequencer that drives the west edge of `mac_array`. It collects one weight set and one activation burst through valid/ready streams into internal buffers. It then replays them as the row-skewed `in_w` stream with the matching `inst_w` instructions: weight load, then a single execute pulse, then activation streaming. It sits between the SRAM/loader logic and `mac_array`, and signals completion once the array pipeline has drained.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_array_ctrl_skew_line.sv | 34 +++
 rtl/mac_array_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_array west-edge sequencer: instruction bit
// positions, sequencer states and the instruction-word builder.
package mac_pkg;

   localparam int INST_MODE  = 2;
   localparam int INST_EXEC  = 1;
   localparam int INST_WLOAD = 0;

   typedef enum logic [2:0] {
      IDLE,
      W_FILL,
      A_FILL,
      W_PLAY,
      EXEC,
      A_PLAY,
      DRAIN
   } state_e;

   function automatic logic [2:0] inst_word(input logic m, input logic exec, input logic wload);
      logic [2:0] w;
      w             = '0;
      w[INST_MODE]  = m;
      w[INST_EXEC]  = exec;
      w[INST_WLOAD] = wload;
      return w;
   endfunction

endpackage

// File: rtl/mac_array_ctrl_skew_line.sv
// Row-skew delay line: row r of the packed word is delayed by r cycles, so
// row 0 passes straight through. All taps clear on reset.
module skew_line #(
   parameter int row = 2,
   parameter int bw  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [row*2*bw-1:0]   data_i,
   output logic [row*2*bw-1:0]   data_o
);

   localparam int W = 2 * bw;

   for (genvar r = 0; r < row; r++) begin : g_row
      if (r == 0) begin : g_pass
         assign data_o[0 +: W] = data_i[0 +: W];
      end else begin : g_dly
         logic [W-1:0] dly_q [0:r-1];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < r; i++) dly_q[i] <= '0;
            end else begin
               dly_q[0] <= data_i[r*W +: W];
               for (int i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
            end
         end

         assign data_o[r*W +: W] = dly_q[r-1];
      end
   end

endmodule

// File: rtl/mac_array_ctrl.sv
// West-edge sequencer for mac_array: buffers one weight set and one activation
// burst, then replays them row-skewed with weight-load / execute / stream instructions.
module mac_array_ctrl
   import mac_pkg::*;
#(
   parameter int bw      = 2,
   parameter int b_bw    = 4,
   parameter int row     = 2,
   parameter int col     = 2,
   parameter int nij_max = 16,
   parameter int drain   = row + col
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             mode,
   input  logic [$clog2(nij_max+1)-1:0]     nij,
   input  logic                             w_valid,
   output logic                             w_ready,
   input  logic [row*b_bw-1:0]              w_data,
   input  logic                             a_valid,
   output logic                             a_ready,
   input  logic [row*b_bw-1:0]              a_data,
   output logic [2:0]                       inst_w,
   output logic [row*bw*2-1:0]              in_w,
   output logic                             busy,
   output logic                             done
);

   localparam int NIJ_W  = $clog2(nij_max + 1);
   localparam int WIDX_W = $clog2(2 * col);
   localparam int AIDX_W = $clog2(nij_max);
   localparam int CNT_W  = $clog2(nij_max + 2*col + row + drain + 4);
   localparam int DW     = row * b_bw;

   function automatic logic [NIJ_W-1:0] sat_nij(input logic [NIJ_W-1:0] n);
      return (n > NIJ_W'(nij_max)) ? NIJ_W'(nij_max) : n;
   endfunction

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [NIJ_W-1:0]     nij_q, nij_d;
   logic [2:0]           inst_w_q, inst_w_d;
   logic [DW-1:0]        in_w_q, in_w_d;
   logic                 done_q, done_d;
   logic                 w_we, a_we;
   logic [CNT_W-1:0]     k_c, nij_c;
   logic [DW-1:0]        feed, skew_out;

   logic [DW-1:0]        wbuf [0:2*col-1];
   logic [DW-1:0]        abuf [0:nij_max-1];

   assign k_c   = mode_q ? CNT_W'(col) : CNT_W'(2 * col);
   assign nij_c = CNT_W'(nij_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      nij_d    = nij_q;
      inst_w_d = '0;
      done_d   = 1'b0;
      w_ready  = 1'b0;
      a_ready  = 1'b0;
      w_we     = 1'b0;
      a_we     = 1'b0;
      case (state_q)
         IDLE: begin
            // done_q high means the previous run ended this cycle; its start is dropped
            if (start && (nij != '0) && !done_q) begin
               state_d = W_FILL;
               cnt_d   = '0;
               mode_d  = mode;
               nij_d   = sat_nij(nij);
            end
         end
         W_FILL: begin
            w_ready = 1'b1;
            if (w_valid) begin
               w_we = 1'b1;
               if (cnt_q == k_c - CNT_W'(1)) begin
                  state_d = A_FILL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         A_FILL: begin
            a_ready = 1'b1;
            if (a_valid) begin
               a_we = 1'b1;
               if (cnt_q == nij_c - CNT_W'(1)) begin
                  state_d = W_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         W_PLAY: begin
            inst_w_d = inst_word(mode_q, 1'b0, 1'b1);
            if (cnt_q == k_c + CNT_W'(row)) begin
               state_d = EXEC;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EXEC: begin
            inst_w_d = inst_word(mode_q, 1'b1, 1'b0);
            state_d  = A_PLAY;
            cnt_d    = '0;
         end
         A_PLAY: begin
            inst_w_d = inst_word(mode_q, 1'b0, 1'b0);
            if (cnt_q + CNT_W'(2) == nij_c + CNT_W'(row)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            inst_w_d = inst_word(mode_q, 1'b0, 1'b0);
            if (cnt_q == CNT_W'(drain - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Weight feed lags the W_PLAY counter by one to leave the lead-in cycle empty
   always_comb begin
      feed = '0;
      if (state_q == W_PLAY && cnt_q != '0 && cnt_q <= k_c)
         feed = wbuf[WIDX_W'(cnt_q - CNT_W'(1))];
      else if (state_q == A_PLAY && cnt_q < nij_c)
         feed = abuf[AIDX_W'(cnt_q)];
   end

   skew_line #(.row(row), .bw(bw)) u_skew (
      .clk    (clk),
      .reset  (reset),
      .data_i (feed),
      .data_o (skew_out)
   );

   always_comb begin
      in_w_d = '0;
      if (state_q == W_PLAY || state_q == A_PLAY) in_w_d = skew_out;
   end

   always_ff @(posedge clk) begin
      if (w_we) wbuf[WIDX_W'(cnt_q)] <= w_data;
      if (a_we) abuf[AIDX_W'(cnt_q)] <= a_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         nij_q    <= '0;
         inst_w_q <= '0;
         in_w_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         nij_q    <= nij_d;
         inst_w_q <= inst_w_d;
         in_w_q   <= in_w_d;
         done_q   <= done_d;
      end
   end

   assign inst_w = inst_w_q;
   assign in_w   = in_w_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: load/play sequences in both modes,
// fill bubbles, mid-run reset, ignored starts and nij saturation.
module tb_mac_array_ctrl;

   localparam int NIJ_W = 5;

   logic             clk = 1'b0;
   logic             reset, start, mode, w_valid, a_valid;
   logic [NIJ_W-1:0] nij;
   logic [7:0]       w_data, a_data;
   logic             w_ready, a_ready, busy, done;
   logic [2:0]       inst_w;
   logic [7:0]       in_w;

   int checks = 0;
   int errors = 0;

   logic [7:0] wvec     [0:3];
   logic [7:0] cap_in   [0:31];
   logic [2:0] cap_inst [0:31];
   logic       cap_done [0:31];

   localparam logic [7:0] EXP0_IN [0:14] = '{8'h00, 8'h00, 8'h07, 8'h56, 8'h4B, 8'h9A, 8'h80, 8'h00,
                                             8'h00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
   localparam logic [2:0] EXP0_INST [0:14] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                                               3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
   localparam logic [7:0] EXP1_IN [0:12] = '{8'h00, 8'h00, 8'h07, 8'h5B, 8'h90, 8'h00, 8'h00,
                                             8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
   localparam logic [2:0] EXP1_INST [0:12] = '{3'b000, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b110,
                                               3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};

   mac_array_ctrl #(.bw(2), .b_bw(4), .row(2), .col(2), .nij_max(16), .drain(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mode    (mode),
      .nij     (nij),
      .w_valid (w_valid),
      .w_ready (w_ready),
      .w_data  (w_data),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_data  (a_data),
      .inst_w  (inst_w),
      .in_w    (in_w),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic m, input logic [NIJ_W-1:0] n);
      start = 1'b1;
      mode  = m;
      nij   = n;
      tick();
      start = 1'b0;
   endtask

   task automatic fill_w(input int first, input int last, input bit bubble, output bit ok);
      int i = first;
      int guard = 0;
      bit hs;
      while (i < last && guard < 200) begin
         w_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
         w_data  = wvec[i];
         hs      = w_valid && w_ready;
         tick();
         if (hs) i++;
         guard++;
      end
      w_valid = 1'b0;
      w_data  = '0;
      ok      = (i == last);
   endtask

   task automatic fill_a(input int n, input logic [7:0] d, input bit bubble, output bit ok);
      int i = 0;
      int guard = 0;
      bit hs;
      while (i < n && guard < 200) begin
         a_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
         a_data  = d;
         hs      = a_valid && a_ready;
         tick();
         if (hs) i++;
         guard++;
      end
      a_valid = 1'b0;
      a_data  = '0;
      ok      = (i == n);
   endtask

   task automatic capture(input int n);
      for (int j = 0; j <= n; j++) begin
         if (j > 0) tick();
         cap_in[j]   = in_w;
         cap_inst[j] = inst_w;
         cap_done[j] = done;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mode = 1'b0; nij = '0;
      w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({inst_w, in_w, busy, done, w_ready, a_ready} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got inst=%b in=%h busy=%b done=%b wr=%b ar=%b exp all 0",
                  inst_w, in_w, busy, done, w_ready, a_ready);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || w_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got busy=%b w_ready=%b exp 0 0", busy, w_ready);
      end
   endtask

   task automatic test_mode0(input bit bubble);
      bit ok;
      wvec[0] = 8'h57; wvec[1] = 8'h46; wvec[2] = 8'h9B; wvec[3] = 8'h8A;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL m0_idle_busy got %b exp 0", busy);
      end
      issue_start(1'b0, 5'd1);
      checks++;
      if (busy !== 1'b1 || w_ready !== 1'b1) begin
         errors++;
         $display("FAIL m0_busy_rise got busy=%b w_ready=%b exp 1 1", busy, w_ready);
      end
      fill_w(0, 4, bubble, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL m0_fill_w got timeout exp 4 beats");
      end
      fill_a(1, 8'hFF, bubble, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL m0_fill_a got timeout exp 1 beat");
      end
      capture(14);
      for (int j = 0; j <= 14; j++) begin
         checks++;
         if (cap_inst[j] !== EXP0_INST[j] || cap_in[j] !== EXP0_IN[j] || cap_done[j] !== (j == 14)) begin
            errors++;
            $display("FAIL m0_play[%0d] bubble=%0d got inst=%b in=%h done=%b exp inst=%b in=%h done=%b",
                     j, bubble, cap_inst[j], cap_in[j], cap_done[j], EXP0_INST[j], EXP0_IN[j], (j == 14));
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL m0_end_busy got %b exp 0", busy);
      end
      tick();
   endtask

   task automatic test_mode1();
      bit ok;
      wvec[0] = 8'h57; wvec[1] = 8'h9B;
      issue_start(1'b1, 5'd1);
      fill_w(0, 2, 1'b0, ok);
      checks++;
      if (!ok || a_ready !== 1'b1) begin
         errors++;
         $display("FAIL m1_fill_w got ok=%0d a_ready=%b exp 1 1", ok, a_ready);
      end
      fill_a(1, 8'hFF, 1'b0, ok);
      capture(12);
      for (int j = 0; j <= 12; j++) begin
         checks++;
         if (cap_inst[j] !== EXP1_INST[j] || cap_in[j] !== EXP1_IN[j] || cap_done[j] !== (j == 12)) begin
            errors++;
            $display("FAIL m1_play[%0d] got inst=%b in=%h done=%b exp inst=%b in=%h done=%b",
                     j, cap_inst[j], cap_in[j], cap_done[j], EXP1_INST[j], EXP1_IN[j], (j == 12));
         end
      end
      // start raised in the done cycle must be dropped
      issue_start(1'b0, 5'd1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_on_done got busy=%b exp 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || w_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_on_done_next got busy=%b w_ready=%b exp 0 0", busy, w_ready);
      end
   endtask

   task automatic test_midrun_reset();
      bit ok;
      wvec[0] = 8'h57; wvec[1] = 8'h46; wvec[2] = 8'h9B; wvec[3] = 8'h8A;
      issue_start(1'b0, 5'd1);
      fill_w(0, 4, 1'b0, ok);
      fill_a(1, 8'hFF, 1'b0, ok);
      repeat (3) tick();
      checks++;
      if (inst_w !== 3'b001 || in_w !== 8'h56) begin
         errors++;
         $display("FAIL rst_pre got inst=%b in=%h exp 001 56", inst_w, in_w);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (inst_w !== 3'b000 || in_w !== 8'h00 || busy !== 1'b0 || w_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got inst=%b in=%h busy=%b w_ready=%b exp 000 00 0 0",
                  inst_w, in_w, busy, w_ready);
      end
      reset = 1'b1;
      tick();
      issue_start(1'b0, 5'd1);
      fill_w(0, 4, 1'b0, ok);
      fill_a(1, 8'hFF, 1'b0, ok);
      capture(14);
      for (int j = 0; j <= 14; j++) begin
         checks++;
         if (cap_inst[j] !== EXP0_INST[j] || cap_in[j] !== EXP0_IN[j] || cap_done[j] !== (j == 14)) begin
            errors++;
            $display("FAIL rst_rerun[%0d] got inst=%b in=%h done=%b exp inst=%b in=%h done=%b",
                     j, cap_inst[j], cap_in[j], cap_done[j], EXP0_INST[j], EXP0_IN[j], (j == 14));
         end
      end
      tick();
   endtask

   task automatic test_ignored_start();
      bit ok;
      wvec[0] = 8'h57; wvec[1] = 8'h46; wvec[2] = 8'h9B; wvec[3] = 8'h8A;
      issue_start(1'b0, 5'd0);
      checks++;
      if (busy !== 1'b0 || w_ready !== 1'b0) begin
         errors++;
         $display("FAIL nij0_start got busy=%b w_ready=%b exp 0 0", busy, w_ready);
      end
      issue_start(1'b0, 5'd1);
      issue_start(1'b1, 5'd5);
      checks++;
      if (busy !== 1'b1 || w_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_start got busy=%b w_ready=%b exp 1 1", busy, w_ready);
      end
      fill_w(0, 2, 1'b0, ok);
      checks++;
      if (w_ready !== 1'b1 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_k got w_ready=%b a_ready=%b exp 1 0", w_ready, a_ready);
      end
      fill_w(2, 4, 1'b0, ok);
      fill_a(1, 8'hFF, 1'b0, ok);
      capture(14);
      checks++;
      if (cap_inst[1] !== 3'b001 || cap_done[14] !== 1'b1 || cap_in[4] !== 8'h4B) begin
         errors++;
         $display("FAIL busy_start_play got inst=%b done=%b in4=%h exp 001 1 4b",
                  cap_inst[1], cap_done[14], cap_in[4]);
      end
      tick();
   endtask

   task automatic test_nij_sat();
      bit ok;
      int hs_cnt = 0;
      int guard = 0;
      bit seen = 0;
      wvec[0] = 8'h57; wvec[1] = 8'h9B;
      issue_start(1'b1, 5'd31);
      fill_w(0, 2, 1'b0, ok);
      for (int i = 0; i < 20; i++) begin
         a_valid = 1'b1;
         a_data  = 8'hFF;
         if (a_ready) hs_cnt++;
         tick();
      end
      a_valid = 1'b0;
      checks++;
      if (hs_cnt !== 16) begin
         errors++;
         $display("FAIL nij_sat got %0d beats exp 16", hs_cnt);
      end
      while (!seen && guard < 100) begin
         if (done) seen = 1;
         else tick();
         guard++;
      end
      checks++;
      if (!seen || busy !== 1'b0) begin
         errors++;
         $display("FAIL nij_sat_done got seen=%0d busy=%b exp 1 0", seen, busy);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_mode0(1'b0);
      test_mode1();
      test_mode0(1'b1);
      test_midrun_reset();
      test_ignored_start();
      test_nij_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
